// File: rtl/ctrl_word_sequencer_pkg.sv
// Shared types and defaults for the control-word sequencer
// and the LU datapath top.
package ctrl_word_sequencer_pkg;

  localparam int CTRL_WIDTH_DEF      = 72;
  localparam int IMEM_ADDR_WIDTH_DEF = 12;
  localparam int CTRL_COMPLETE_BIT   = 0;

  localparam logic [CTRL_WIDTH_DEF-1:0] IDLE_WORD_DEF = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/ctrl_word_sequencer_skid.sv
// One-entry holding register for the word that is in flight
// from the instruction SRAM when issue stalls.
module ctrl_skid_reg
  import ctrl_word_sequencer_pkg::*;
#(
  parameter int W = CTRL_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_consume,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Streams pre-scheduled control words from the instruction
// SRAM onto the LU datapath CTRL_Signal input.
module ctrl_word_sequencer
  import ctrl_word_sequencer_pkg::*;
#(
  parameter int CTRL_WIDTH      = CTRL_WIDTH_DEF,
  parameter int IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
  parameter logic [CTRL_WIDTH-1:0] IDLE_WORD =
    CTRL_WIDTH'(IDLE_WORD_DEF)
) (
  input  logic                       CLK_100,
  input  logic                       RST,
  input  logic                       start,
  input  logic                       pause,
  input  logic [IMEM_ADDR_WIDTH-1:0] prog_base,
  input  logic [IMEM_ADDR_WIDTH:0]   prog_len,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_en,
  input  logic [CTRL_WIDTH-1:0]      imem_dout,
  output logic [CTRL_WIDTH-1:0]      CTRL_Signal,
  output logic                       ctrl_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overrun,
  output logic [IMEM_ADDR_WIDTH:0]   issued_count
);

  localparam int AW = IMEM_ADDR_WIDTH;
  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [AW-1:0]         r_pc;
  logic [AW:0]           r_len;
  logic [AW:0]           r_fcnt;
  logic [AW:0]           r_icnt;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic                  r_vld;
  logic                  r_inf;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_run;
  logic                  w_issue;
  logic                  w_cmpl;
  logic                  w_last;
  logic                  w_term;
  logic                  w_fetch;
  logic                  w_skid_vld;
  logic [CTRL_WIDTH-1:0] w_skid_data;

  assign w_run   = (r_state == S_FETCH) || (r_state == S_RUN);
  assign w_issue = w_run && r_vld && !pause;
  assign w_cmpl  = w_issue && r_ctrl[CTRL_COMPLETE_BIT];
  assign w_last  = w_issue && ((r_icnt + CNT_ONE) == r_len);
  assign w_term  = w_cmpl || w_last;
  // Terminating word cancels the fetch issued alongside it
  assign w_fetch = w_run && !pause && (r_fcnt != r_len) && !w_term;

  ctrl_skid_reg #(
    .W (CTRL_WIDTH)
  ) u_skid (
    .clk       (CLK_100),
    .rst       (RST),
    .i_load    (w_run && pause && r_inf),
    .i_consume (w_run && !pause && w_skid_vld),
    .i_clear   (w_term),
    .i_data    (imem_dout),
    .o_valid   (w_skid_vld),
    .o_data    (w_skid_data)
  );

  always_ff @(posedge CLK_100) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (prog_len == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_term) begin
          w_state_nxt = S_FINISH;
        end else if (w_fetch) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_term) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_100) begin
    if (RST) begin
      r_pc   <= '0;
      r_len  <= '0;
      r_fcnt <= '0;
      r_icnt <= '0;
      r_ctrl <= IDLE_WORD;
      r_vld  <= 1'b0;
      r_inf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      r_inf  <= w_fetch;
      if (r_state == S_FINISH) begin
        r_busy <= 1'b0;
      end
      if (r_state == S_IDLE && start) begin
        r_pc   <= prog_base;
        r_len  <= prog_len;
        r_fcnt <= '0;
        r_icnt <= '0;
        r_vld  <= 1'b0;
        r_busy <= 1'b1;
        r_err  <= (prog_len == '0);
      end
      if (w_fetch) begin
        r_pc   <= r_pc + PC_ONE;
        r_fcnt <= r_fcnt + CNT_ONE;
      end
      if (w_issue) begin
        r_icnt <= r_icnt + CNT_ONE;
      end
      if (w_last && !w_cmpl) begin
        r_err <= 1'b1;
      end
      // Skid word predates the SRAM output, so it goes first
      if (w_term) begin
        r_vld <= 1'b0;
      end else if (w_run && !pause) begin
        if (w_skid_vld) begin
          r_ctrl <= w_skid_data;
          r_vld  <= 1'b1;
        end else if (r_inf) begin
          r_ctrl <= imem_dout;
          r_vld  <= 1'b1;
        end else begin
          r_vld  <= 1'b0;
        end
      end
    end
  end

  assign imem_addr    = r_pc;
  assign imem_en      = w_fetch;
  assign CTRL_Signal  = w_issue ? r_ctrl : IDLE_WORD;
  assign ctrl_valid   = w_issue;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_overrun  = r_err;
  assign issued_count = r_icnt;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Directed bench for ctrl_word_sequencer with a 1-cycle
// synchronous-read instruction memory model.
module tb_ctrl_word_sequencer;

  localparam int CW = 72;
  localparam int AW = 12;

  logic          CLK_100 = 1'b0;
  logic          RST;
  logic          start;
  logic          pause;
  logic [AW-1:0] prog_base;
  logic [AW:0]   prog_len;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [CW-1:0] imem_dout = '0;
  logic [CW-1:0] CTRL_Signal;
  logic          ctrl_valid;
  logic          busy;
  logic          done;
  logic          err_overrun;
  logic [AW:0]   issued_count;

  bit cbit [4096];
  int errors = 0;
  int checks = 0;

  ctrl_word_sequencer dut (
    .CLK_100      (CLK_100),
    .RST          (RST),
    .start        (start),
    .pause        (pause),
    .prog_base    (prog_base),
    .prog_len     (prog_len),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .imem_dout    (imem_dout),
    .CTRL_Signal  (CTRL_Signal),
    .ctrl_valid   (ctrl_valid),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun),
    .issued_count (issued_count)
  );

  always #5 CLK_100 = ~CLK_100;

  function automatic logic [CW-1:0] mk(input logic [AW-1:0] a);
    mk = {8'h5A, a, 51'(a) * 51'd7 + 51'd1, cbit[a]};
  endfunction

  always @(posedge CLK_100) begin
    if (imem_en) imem_dout <= mk(imem_addr);
  end

  task automatic tick;
    @(posedge CLK_100);
    #1;
  endtask

  task automatic clear_prog;
    for (int a = 0; a < 4096; a++) cbit[a] = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; pause = 1'b0;
    prog_base = '0; prog_len = '0;
    tick; tick; tick;
    @(negedge CLK_100);
    checks++;
    if (CTRL_Signal !== '0 || ctrl_valid !== 1'b0 || busy !== 1'b0
        || done !== 1'b0 || err_overrun !== 1'b0 || imem_en !== 1'b0
        || imem_addr !== '0 || issued_count !== '0) begin
      errors++;
      $display("FAIL reset got sig=%h v=%b b=%b d=%b e=%b en=%b a=%h n=%0d exp all zero",
               CTRL_Signal, ctrl_valid, busy, done, err_overrun,
               imem_en, imem_addr, issued_count);
    end
    RST = 1'b0;
    tick;
  endtask

  task automatic test_complete;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic [AW-1:0] a;
    clear_prog();
    cbit[12'h014] = 1'b1;
    prog_base = 12'h010; prog_len = 13'd16;
    for (int i = 0; i < 12; i++) begin
      start = (i == 0);
      exp_v = (i >= 3 && i <= 7);
      a = 12'h010 + 12'(i - 3);
      exp_w = exp_v ? mk(a) : '0;
      @(negedge CLK_100);
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w) begin
        errors++;
        $display("FAIL cmpl_word cyc=%0d got v=%b %h exp v=%b %h",
                 i, ctrl_valid, CTRL_Signal, exp_v, exp_w);
      end
      checks++;
      if (done !== (i == 9) || busy !== (i >= 1 && i <= 8)) begin
        errors++;
        $display("FAIL cmpl_ctl cyc=%0d got done=%b busy=%b exp done=%b busy=%b",
                 i, done, busy, i == 9, i >= 1 && i <= 8);
      end
      tick;
    end
    start = 1'b0;
    @(negedge CLK_100);
    checks++;
    if (issued_count !== 13'd5 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL cmpl_end got n=%0d err=%b exp n=5 err=0",
               issued_count, err_overrun);
    end
    tick;
  endtask

  task automatic test_overrun;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic [AW-1:0] a;
    clear_prog();
    prog_base = 12'h100; prog_len = 13'd3;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      exp_v = (i >= 3 && i <= 5);
      a = 12'h100 + 12'(i - 3);
      exp_w = exp_v ? mk(a) : '0;
      @(negedge CLK_100);
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w) begin
        errors++;
        $display("FAIL ovr_word cyc=%0d got v=%b %h exp v=%b %h",
                 i, ctrl_valid, CTRL_Signal, exp_v, exp_w);
      end
      checks++;
      if (done !== (i == 7) || err_overrun !== (i >= 6)) begin
        errors++;
        $display("FAIL ovr_ctl cyc=%0d got done=%b err=%b exp done=%b err=%b",
                 i, done, err_overrun, i == 7, i >= 6);
      end
      tick;
    end
    start = 1'b0;
    @(negedge CLK_100);
    checks++;
    if (issued_count !== 13'd3 || err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_end got n=%0d err=%b exp n=3 err=1",
               issued_count, err_overrun);
    end
    tick;
  endtask

  task automatic test_pause;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic          exp_en;
    logic [AW-1:0] a;
    clear_prog();
    cbit[12'h209] = 1'b1;
    prog_base = 12'h200; prog_len = 13'd16;
    for (int i = 0; i < 21; i++) begin
      start = (i == 0);
      pause = (i >= 5 && i <= 8);
      exp_v = (i >= 3 && i <= 4) || (i >= 9 && i <= 16);
      exp_en = (i >= 1 && i <= 4) || (i >= 9 && i <= 15);
      a = 12'h200 + ((i <= 4) ? 12'(i - 3) : 12'(i - 7));
      exp_w = exp_v ? mk(a) : '0;
      @(negedge CLK_100);
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w) begin
        errors++;
        $display("FAIL pause_word cyc=%0d got v=%b %h exp v=%b %h",
                 i, ctrl_valid, CTRL_Signal, exp_v, exp_w);
      end
      checks++;
      if (imem_en !== exp_en || done !== (i == 18)) begin
        errors++;
        $display("FAIL pause_ctl cyc=%0d got en=%b done=%b exp en=%b done=%b",
                 i, imem_en, done, exp_en, i == 18);
      end
      checks++;
      if (i == 1 && err_overrun !== 1'b0) begin
        errors++;
        $display("FAIL pause_errclr got err=%b exp 0", err_overrun);
      end
      tick;
    end
    start = 1'b0; pause = 1'b0;
    @(negedge CLK_100);
    checks++;
    if (issued_count !== 13'd10 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL pause_end got n=%0d err=%b exp n=10 err=0",
               issued_count, err_overrun);
    end
    tick;
  endtask

  task automatic test_wrap;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic          exp_en;
    logic [AW-1:0] a;
    logic [AW-1:0] fa;
    clear_prog();
    cbit[12'h001] = 1'b1;
    prog_base = 12'hFFE; prog_len = 13'd4;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      exp_en = (i >= 1 && i <= 4);
      fa = 12'hFFE + 12'(i - 1);
      exp_v = (i >= 3 && i <= 6);
      a = 12'hFFE + 12'(i - 3);
      exp_w = exp_v ? mk(a) : '0;
      @(negedge CLK_100);
      checks++;
      if (imem_en !== exp_en || (exp_en && imem_addr !== fa)) begin
        errors++;
        $display("FAIL wrap_addr cyc=%0d got en=%b a=%h exp en=%b a=%h",
                 i, imem_en, imem_addr, exp_en, fa);
      end
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w
          || done !== (i == 8)) begin
        errors++;
        $display("FAIL wrap_word cyc=%0d got v=%b %h d=%b exp v=%b %h d=%b",
                 i, ctrl_valid, CTRL_Signal, done, exp_v, exp_w, i == 8);
      end
      tick;
    end
    start = 1'b0;
    @(negedge CLK_100);
    checks++;
    if (issued_count !== 13'd4 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got n=%0d err=%b exp n=4 err=0",
               issued_count, err_overrun);
    end
    tick;
  endtask

  task automatic test_zero_len;
    clear_prog();
    prog_base = 12'h050; prog_len = 13'd0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      @(negedge CLK_100);
      checks++;
      if (imem_en !== 1'b0 || ctrl_valid !== 1'b0 || busy !== (i == 1)
          || done !== (i == 2) || err_overrun !== (i >= 1)) begin
        errors++;
        $display("FAIL zero_len cyc=%0d got en=%b v=%b b=%b d=%b e=%b exp en=0 v=0 b=%b d=%b e=%b",
                 i, imem_en, ctrl_valid, busy, done, err_overrun,
                 i == 1, i == 2, i >= 1);
      end
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_start_while_busy;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic [AW-1:0] a;
    logic [AW:0]   exp_n;
    clear_prog();
    cbit[12'h304] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      start = (i == 0) || (i >= 2 && i <= 6);
      prog_base = (i == 0) ? 12'h300 : 12'h500;
      prog_len = (i == 0) ? 13'd16 : 13'd2;
      exp_v = (i >= 3 && i <= 7);
      a = 12'h300 + 12'(i - 3);
      exp_w = exp_v ? mk(a) : '0;
      exp_n = (i <= 3) ? 13'd0 : (i >= 8) ? 13'd5 : 13'(i - 3);
      @(negedge CLK_100);
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w) begin
        errors++;
        $display("FAIL busy_word cyc=%0d got v=%b %h exp v=%b %h",
                 i, ctrl_valid, CTRL_Signal, exp_v, exp_w);
      end
      checks++;
      if (issued_count !== exp_n || done !== (i == 9)) begin
        errors++;
        $display("FAIL busy_cnt cyc=%0d got n=%0d d=%b exp n=%0d d=%b",
                 i, issued_count, done, exp_n, i == 9);
      end
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [CW-1:0] exp_w;
    logic          exp_v;
    logic [AW-1:0] a;
    clear_prog();
    prog_base = 12'h400; prog_len = 13'd16;
    for (int i = 0; i < 14; i++) begin
      start = (i == 0);
      RST = (i == 6 || i == 7);
      exp_v = (i >= 3 && i <= 6);
      a = 12'h400 + 12'(i - 3);
      exp_w = exp_v ? mk(a) : '0;
      @(negedge CLK_100);
      checks++;
      if (ctrl_valid !== exp_v || CTRL_Signal !== exp_w) begin
        errors++;
        $display("FAIL rst_word cyc=%0d got v=%b %h exp v=%b %h",
                 i, ctrl_valid, CTRL_Signal, exp_v, exp_w);
      end
      checks++;
      if (i >= 7 && (busy !== 1'b0 || imem_en !== 1'b0 || done !== 1'b0
          || imem_addr !== '0)) begin
        errors++;
        $display("FAIL rst_ctl cyc=%0d got b=%b en=%b d=%b a=%h exp all zero",
                 i, busy, imem_en, done, imem_addr);
      end
      tick;
    end
    start = 1'b0; RST = 1'b0;
    @(negedge CLK_100);
    checks++;
    if (issued_count !== '0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_end got n=%0d err=%b exp n=0 err=0",
               issued_count, err_overrun);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_complete();
    test_overrun();
    test_pause();
    test_wrap();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
- Upstream feeder of the LU-decomposition datapath. Fetches pre-scheduled control words from a synchronous-read instruction SRAM and drives the datapath `CTRL_Signal` input with one word per cycle.
- Terminates on the word whose bit 0 ("complete") is set, or on a length limit. Supports pause/resume with no lost or duplicated words.
- Sits between the host-loaded instruction memory (same 1-cycle-read SRAM macro family as the data banks) and the datapath.

Parameters:
- CTRL_WIDTH, 72, width of one control word / `CTRL_Signal`
- IMEM_ADDR_WIDTH, 12, instruction memory address width
- IDLE_WORD, 0, word driven on `CTRL_Signal` whenever no valid word is issued

Ports:
- CLK_100  in  1  system clock
- RST  in  1  synchronous, active-high reset
- start  in  1  begin program; sampled only in IDLE
- pause  in  1  stall issue; level-sensitive
- prog_base  in  IMEM_ADDR_WIDTH  first instruction address; sampled with start
- prog_len  in  IMEM_ADDR_WIDTH+1  maximum words to issue; sampled with start
- imem_addr  out  IMEM_ADDR_WIDTH  instruction SRAM address
- imem_en  out  1  instruction SRAM read enable (active-high; polarity adaption is external)
- imem_dout  in  CTRL_WIDTH  SRAM read data, valid the cycle after imem_en=1
- CTRL_Signal  out  CTRL_WIDTH  registered control word to datapath
- ctrl_valid  out  1  CTRL_Signal holds a program word this cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on termination
- err_overrun  out  1  sticky; prog_len reached without complete bit; cleared on next accepted start
- issued_count  out  IMEM_ADDR_WIDTH+1  words issued in the current or last run

Behaviour:
- Reset values: CTRL_Signal=IDLE_WORD; ctrl_valid, busy, done, err_overrun, imem_en = 0; imem_addr = 0; issued_count = 0; state IDLE; skid register empty.
- States: IDLE, FETCH, RUN, FINISH.
- IDLE:
  - start=1 captures prog_base into pc and prog_len into the length limit, clears issued_count and err_overrun, and moves to FETCH.
  - start while busy is ignored.
- prog_len=0: start goes to FINISH directly. No fetch occurs. err_overrun=1; done pulses the next cycle.
- Fetch:
  - imem_addr = pc combinationally.
  - imem_en = 1 in FETCH/RUN when pause=0 and the fetch limit (prog_len words requested) is not reached.
  - pc increments on each enabled fetch and wraps modulo 2^IMEM_ADDR_WIDTH.
- Latency: start sampled at edge t gives the first fetch in cycle t+1. Word0 appears on CTRL_Signal with ctrl_valid=1 in cycle t+3. After that, one word per cycle while pause=0.
- Pause:
  - While pause=1: imem_en=0, pc holds, CTRL_Signal=IDLE_WORD, ctrl_valid=0.
  - The single in-flight word (fetched the cycle pause rose) is captured into a one-entry skid register.
  - On release, the skid word is issued first, then the stream continues gap-free.
  - Pause has no effect in IDLE/FINISH.
- issued_count increments on every cycle with ctrl_valid=1.
- Complete termination: when the issued word has bit 0=1, the next fetch is cancelled and any in-flight or skid word is discarded. Next cycle: CTRL_Signal=IDLE_WORD, ctrl_valid=0, state FINISH.
- Overrun termination: issuing the prog_len-th word without bit 0 set terminates the same way and sets err_overrun=1.
- Simultaneous complete bit and length limit: the complete bit wins; err_overrun stays 0.
- FINISH: done=1 for exactly one cycle, busy drops the same cycle, return to IDLE.
- RST mid-run: all outputs return to reset values on the next edge; the program is abandoned with no done pulse.

Decomposition:
- Shared package holds:
  - state enum (IDLE/FETCH/RUN/FINISH)
  - CTRL_COMPLETE_BIT = 0
  - default IDLE_WORD
  - CTRL_WIDTH/IMEM_ADDR_WIDTH defaults, shared with the datapath top
- One sub-module: ctrl_skid_reg, a one-entry CTRL_WIDTH holding register with load/valid/consume.

Test Plan:
- Program at base 0x010, complete bit on word 4, prog_len=16, start at cycle 0 -> words 0..4 on cycles 3..7 with ctrl_valid=1; IDLE_WORD on cycle 8; done at cycle 9; issued_count=5; err_overrun=0.
- prog_len=3, no complete bit -> 3 words issued; done pulses; err_overrun=1 until the next start.
- pause=1 for cycles 5..8 during a 10-word program -> ctrl_valid=0 on cycles 5..8; the word sequence is unchanged with no gaps after release; total issued=10.
- prog_base=0xFFE, 4 words -> imem_addr sequence FFE, FFF, 000, 001.
- prog_len=0 -> no imem_en; done one cycle after busy; err_overrun=1. Separately, start asserted while busy -> no restart and issued_count unaffected.
- RST asserted at cycle 6 of a run -> next cycle CTRL_Signal=IDLE_WORD, busy=0, imem_en=0, no done pulse.
